// File: rtl/rotate_left_iter.sv
// rtl/rotate_left_iter.sv - multi-cycle left rotator, one bit position per clock
module rotate_left_iter #(
  parameter int W  = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [W-1:0]  a,
  input  logic [AW-1:0] amt,
  output logic          ready,
  output logic          done_tick,
  output logic [W-1:0]  y
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  r_q, r_d;
  logic [AW-1:0] n_q, n_d;

  // State, working register and remaining count; reset aborts any operation in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      n_q     <= n_d;
    end
  end

  // Next-state logic: capture in IDLE, rotate one place per cycle in OP, pulse in DONE
  always_comb begin
    state_d   = state_q;
    r_d       = r_q;
    n_d       = n_q;
    ready     = 1'b0;
    done_tick = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          r_d     = a;
          n_d     = amt;
          state_d = S_OP;
        end
      end
      S_OP: begin
        // n only decrements while non-zero, so it can never wrap
        if (n_q != '0) begin
          r_d = {r_q[W-2:0], r_q[W-1]};
          n_d = n_q - AW'(1);
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_tick = 1'b1;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign y = r_q;

endmodule

// File: tb/tb_rotate_left_iter.sv
// tb/tb_rotate_left_iter.sv - randomized self-checking bench for rotate_left_iter
module tb_rotate_left_iter;

  logic       clk;
  logic       reset_n;
  logic       start;
  logic [7:0] a;
  logic [2:0] amt;
  logic       ready;
  logic       done_tick;
  logic [7:0] y;

  int total = 0;
  int bad   = 0;

  rotate_left_iter #(.W(8), .AW(3)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .a         (a),
    .amt       (amt),
    .ready     (ready),
    .done_tick (done_tick),
    .y         (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference: a left rotation by k equals a right rotation by (8-k) mod 8
  function automatic logic [7:0] ref_rot(input logic [7:0] v, input int k);
    int          rk;
    logic [15:0] dbl;
    rk  = (8 - k) % 8;
    dbl = {v, v} >> rk;
    return dbl[7:0];
  endfunction

  // Accept one operation at the next edge, then follow it to completion.
  // Called at a negedge while the DUT is idle; returns at the negedge after done_tick.
  task automatic run_op(input string tag, input logic [7:0] av, input logic [2:0] kv);
    int cyc;
    check({tag, " ready_before"}, ready, 1'b1);
    start = 1'b1;
    a     = av;
    amt   = kv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = 8'($urandom);
    amt   = 3'($urandom);
    @(negedge clk);
    cyc = 1;
    check({tag, " ready_c1"}, ready, 1'b0);
    while (!done_tick && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " done_seen"}, done_tick, 1'b1);
    check({tag, " latency"}, cyc, kv + 2);
    check({tag, " y"}, y, ref_rot(av, kv));
    @(negedge clk);
    check({tag, " done_width"}, done_tick, 1'b0);
    check({tag, " ready_after"}, ready, 1'b1);
    check({tag, " y_hold"}, y, ref_rot(av, kv));
  endtask

  initial begin
    int cyc;
    int dones;
    int last_acc;
    int accs;
    logic prev_done;

    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    amt     = '0;
    repeat (2) @(negedge clk);
    check("reset y", y, 8'h00);
    check("reset ready", ready, 1'b1);
    check("reset done", done_tick, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // Directed cases
    run_op("t81_1", 8'h81, 3'd1);
    run_op("tB4_0", 8'hB4, 3'd0);
    run_op("t01_7", 8'h01, 3'd7);

    // start during OP and during DONE must be ignored
    start = 1'b1; a = 8'h0F; amt = 3'd4;
    @(posedge clk); #1; start = 1'b0;
    dones = 0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; a = 8'hFF; amt = 3'd1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!done_tick && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("ign done_seen", done_tick, 1'b1);
    dones++;
    start = 1'b1; a = 8'hFF; amt = 3'd1;
    @(negedge clk);
    start = 1'b0;
    check("ign ready", ready, 1'b1);
    check("ign y", y, 8'hF0);
    for (int i = 0; i < 10; i++) begin
      if (done_tick) dones++;
      check("ign stays_idle", ready, 1'b1);
      @(negedge clk);
    end
    check("ign done_count", dones, 1);

    // Asynchronous reset in the middle of an operation
    start = 1'b1; a = 8'h5A; amt = 3'd6;
    @(posedge clk); #1; start = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("arst y", y, 8'h00);
    check("arst ready", ready, 1'b1);
    check("arst done", done_tick, 1'b0);
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_tick) dones++;
    end
    check("arst no_done", dones, 0);
    reset_n = 1'b1;
    @(negedge clk);
    run_op("t5A_6", 8'h5A, 3'd6);

    // start held high continuously: accepts every amt+3 cycles
    start = 1'b1; a = 8'hC3; amt = 3'd2;
    last_acc  = -1;
    accs      = 0;
    prev_done = 1'b0;
    for (int c = 0; c < 26; c++) begin
      if (ready) begin
        if (last_acc >= 0) check("b2b spacing", c - last_acc, 5);
        last_acc = c;
        accs++;
      end
      if (done_tick) begin
        check("b2b y", y, 8'h0F);
        check("b2b pulse_width", prev_done, 1'b0);
      end
      prev_done = done_tick;
      @(negedge clk);
    end
    check("b2b accepts", accs, 6);
    start = 1'b0;
    cyc = 0;
    while (!ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("b2b drain", ready, 1'b1);

    // Full sweep over every operand and amount, visited in a random order per amount
    for (int k = 0; k < 8; k++) begin
      int off;
      off = int'($urandom_range(0, 255));
      for (int v = 0; v < 256; v++) begin
        run_op("sweep", 8'((v + off) % 256), 3'(k));
      end
    end

    // Extra random operations
    for (int i = 0; i < 64; i++) begin
      run_op("rand", 8'($urandom), 3'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotate_left_iter.md
Name: rotate_left_iter

Overview:
- Multi-cycle left rotator. It rotates an operand left by `amt` positions, one bit per clock.
- It is the inverse-direction, area-lean counterpart of the team's combinational right-rotating barrel shifter. For any k, a left rotation by k undoes a right rotation by k.
- It sits in datapaths where a single-bit-per-cycle rotate is acceptable. Handshaking uses a start/ready/done_tick scheme.

Parameters:
- W, 8, operand width in bits.
- AW, 3, width of the rotate amount. W must equal 2**AW.

Ports:
- clk  input  1  system clock. The block uses a single clock domain and all state changes on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled only in state IDLE.
- a  input  W  operand. Captured on the edge where start is accepted.
- amt  input  AW  left-rotate amount, 0..W-1. Captured together with a.
- ready  output  1  high while in IDLE. Combinational from state.
- done_tick  output  1  one-cycle pulse in state DONE. Combinational from state.
- y  output  W  result register. Valid from the done_tick cycle until the next accepted start.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state <= IDLE, r <= 0, n <= 0.
  - Therefore y=0, ready=1, done_tick=0.
  - Reset asserted mid-operation aborts immediately and no done_tick is produced.
  - Release of reset is synchronous to clk. The first possible accept is on the first rising edge with reset_n=1.
- Registers:
  - r[W-1:0] is the working/result register, and y = r.
  - n[AW-1:0] is the remaining rotate count.
- FSM states: IDLE, OP, DONE.
- IDLE:
  - ready=1.
  - If start=1: r <= a, n <= amt, go to OP.
  - Otherwise hold, with r unchanged so y retains the last result.
- OP:
  - ready=0.
  - If n != 0: r <= {r[W-2:0], r[W-1]} and n <= n-1. Stay in OP.
  - If n == 0: go to DONE, with r unchanged.
- DONE:
  - done_tick=1 and ready=0.
  - Unconditionally go to IDLE on the next edge.
- Latency: start sampled at the end of cycle 0 gives done_tick high in cycle amt+2.
  - amt=0 gives latency 2.
  - amt=W-1 gives latency W+1.
- Throughput: the next start can be accepted in the cycle after done_tick, so back-to-back operations are spaced amt+3 cycles apart.
- start while not in IDLE (OP or DONE) is ignored.
  - a and amt are not re-sampled.
  - The operation in progress is unaffected.
- a and amt may change freely after the accept edge. Only the captured copies are used.
- Arithmetic rules:
  - Pure rotation with no fill bits. The popcount of r is invariant across OP.
  - n decrements only when n != 0, so it never wraps.
- Boundary cases:
  - amt=0 gives y=a.
  - amt=W-1 is equivalent to rotate right by 1.
  - Result identity: y == rotate_right(a, (W-amt) mod W). This holds for all a and amt.
- No X propagation. All state elements are reset.

Test Plan:
- Reset then a=8'h81, amt=1, start pulsed in cycle 0 -> ready drops in cycle 1, done_tick=1 only in cycle 3, y=8'h03, ready=1 in cycle 4.
- a=8'hB4, amt=0 -> done_tick in cycle 2, y=8'hB4. Next, a=8'h01, amt=7 -> done_tick 9 cycles after its accept, y=8'h80.
- Accept a=8'h0F, amt=4, then pulse start with a=8'hFF, amt=1 during OP and again during DONE -> both ignored, y=8'hF0, exactly one done_tick.
- Accept a=8'h5A, amt=6, then assert reset_n=0 asynchronously mid-OP (between edges) -> y=0, ready=1 immediately, no done_tick. After release, accept a=8'h5A, amt=6 -> y=8'h96.
- Back-to-back: start held high continuously with a=8'hC3, amt=2 -> an accept occurs every 5 cycles, each result y=8'h0F, done_tick pulses exactly 1 cycle wide.
- Exhaustive/random sweep over all a (256 values) and amt (0..7) -> y matches the right-rotate-by-((8-amt) mod 8) reference model, and latency equals amt+2 in every case.
